// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU slice sequencer.
// Imported by the sequencer, its p/g generator and the bench.
package alu_pkg;

    localparam int SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request, slice and result buses of the slice sequencer.
// master = sequencer side, slave = requester/slice/consumer side.
interface alu_slice_sequencer_if #(
    parameter int WORD_W = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic [3:0]        in_s;
    logic              in_m;
    logic              in_cn_n;

    logic [3:0]        sl_p;
    logic [3:0]        sl_g;
    logic              sl_m;
    logic              sl_ci_n;
    logic              sl_valid;
    logic [3:0]        sl_y;
    logic              sl_pg_n;
    logic              sl_gg_n;
    logic              sl_aeqb;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_y;
    logic              out_cout_n;
    logic              out_aeqb;

    modport master (
        input  in_valid, in_a, in_b, in_s, in_m, in_cn_n,
        output in_ready,
        output sl_p, sl_g, sl_m, sl_ci_n, sl_valid,
        input  sl_y, sl_pg_n, sl_gg_n, sl_aeqb,
        output out_valid, out_y, out_cout_n, out_aeqb,
        input  out_ready
    );

    modport slave (
        output in_valid, in_a, in_b, in_s, in_m, in_cn_n,
        input  in_ready,
        input  sl_p, sl_g, sl_m, sl_ci_n, sl_valid,
        output sl_y, sl_pg_n, sl_gg_n, sl_aeqb,
        input  out_valid, out_y, out_cout_n, out_aeqb,
        output out_ready
    );

endinterface

// File: rtl/alu_slice_sequencer_pg_gen.sv
// Per-bit propagate/generate terms for one 4-bit 74181-style slice.
// Purely combinational; S selects the function of A and B.
module alu_pg_gen
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [3:0]         s,
    output logic [SLICE_W-1:0] p,
    output logic [SLICE_W-1:0] g
);

    // first-level 74181 terms, replicated across the slice bits
    always_comb begin
        p = ~(a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}}));
        g = ~((a & ~b & {SLICE_W{s[2]}}) | (a & b & {SLICE_W{s[3]}}));
    end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Drives one external 4-bit ALU slice over several cycles, LSB first,
// rippling the carry between slices and assembling the full result.
module alu_slice_sequencer
    import alu_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_slice_sequencer_if.master bus
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   y_q;
    logic [3:0]          s_q;
    logic                m_q;
    logic                ci_n;
    logic                aeqb_q;
    logic [SLICE_W-1:0]  a_cur;
    logic [SLICE_W-1:0]  b_cur;
    logic [SLICE_W-1:0]  p_w;
    logic [SLICE_W-1:0]  g_w;
    logic                run;
    logic                ci_n_next;

    // pick the operand nibbles of the slice being processed
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IW'(k)) begin
                a_cur = a_q[k*SLICE_W +: SLICE_W];
                b_cur = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    alu_pg_gen u_pg (
        .a (a_cur),
        .b (b_cur),
        .s (s_q),
        .p (p_w),
        .g (g_w)
    );

    assign run       = (state == ST_RUN);
    assign ci_n_next = bus.sl_gg_n & (bus.sl_pg_n | ci_n);

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.sl_valid   = run;
    assign bus.sl_p       = run ? p_w : 4'hF;
    assign bus.sl_g       = run ? g_w : 4'hF;
    assign bus.sl_m       = m_q;
    assign bus.sl_ci_n    = ci_n;
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.out_y      = y_q;
    assign bus.out_cout_n = ci_n;
    assign bus.out_aeqb   = aeqb_q;

    // sequencer: accept, walk the slices, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            m_q    <= 1'b0;
            ci_n   <= 1'b1;
            y_q    <= '0;
            aeqb_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        s_q    <= bus.in_s;
                        m_q    <= bus.in_m;
                        ci_n   <= bus.in_cn_n;
                        idx    <= '0;
                        aeqb_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx == IW'(k)) begin
                            y_q[k*SLICE_W +: SLICE_W] <= bus.sl_y;
                        end
                    end
                    aeqb_q <= aeqb_q & bus.sl_aeqb;
                    ci_n   <= ci_n_next;
                    if (idx == LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
